fifo_word_reader: RTL and testbench
===================================

// Module: fifo_word_reader
// PURPOSE
//  Consumer for the byte FIFO. Issues rd pops against FIFO empty, absorbs the 1-cycle read latency,
//  packs BYTES bytes little-endian into a word, presents words on a valid/ready master port.
//  Flush pulse emits a trailing partial word with keep mask. Sits between byte FIFO and word-wide sink.
// PARAMETERS
//  DATA_W  8  FIFO byte width
//  BYTES   4  bytes per output word; >=2; word width = DATA_W*BYTES
// PORTS
//  clk         in   1               clock, all logic on rising edge
//  rst         in   1               reset, synchronous, active-high
//  fifo_empty  in   1               FIFO empty flag
//  fifo_rd     out  1               pop request; data returns next cycle
//  fifo_data   in   DATA_W          FIFO read data, valid cycle after fifo_rd
//  flush       in   1               1-cycle pulse: emit partial word
//  m_valid     out  1               output word valid
//  m_ready     in   1               sink accepts when m_valid&&m_ready
//  m_data      out  DATA_W*BYTES    packed word; first popped byte in [DATA_W-1:0]
//  m_keep      out  BYTES           byte-valid mask, LSB-contiguous
//  m_last      out  1               word produced by flush
//  busy        out  1               fill_cnt!=0 || inflight || m_valid || flush_pend
// BEHAVIOUR
//  Reset (rst=1 at edge): fifo_rd=0, m_valid=0, m_data=0, m_keep=0, m_last=0, busy=0;
//   fill_cnt=0, inflight=0, flush_pend=0, assembly reg=0. Mid-operation reset discards in-flight
//   byte: fifo_data in the cycle after reset is ignored. fifo_rd is 0 while rst=1.
//  State: assembly reg + fill_cnt (0..BYTES), inflight (1 bit = fifo_rd registered), output reg.
//  Pop rule (combinational fifo_rd), only when !rst && !fifo_empty && !flush_pend and either:
//   (a) fill_cnt+inflight < BYTES, or
//   (b) inflight && fill_cnt==BYTES-1 && (!m_valid || m_ready)  [keeps 1 byte/cycle].
//  Never pops with fifo_empty=1. Never more than one byte in flight.
//  Byte arrival (inflight=1): byte written to lane fill_cnt, fill_cnt+1.
//  Word transfer: when word complete (stored or completing this cycle) and (!m_valid || m_ready):
//   output reg <= word, m_keep=all 1s, m_last=0, m_valid=1; fill_cnt<=0, assembly cleared.
//   If slot busy, full word held in assembly; pops stop by rule (a) until transfer.
//  Output hold: m_data/m_keep/m_last stable while m_valid && !m_ready.
//   m_valid drops after acceptance unless a new word loads same cycle.
//  Throughput: m_ready held 1, one byte/cycle sustained, one word every BYTES cycles, no bubble.
//  Latency: first pop at cycle N -> m_valid at N+BYTES+1.
//  Flush: pulse sets flush_pend; pops blocked. When inflight==0 and slot free:
//   fill_cnt>0 -> emit partial: unused lanes zero, m_keep low fill_cnt bits set, m_last=1;
//   fill_cnt==0 -> no word emitted.
//   flush_pend clears on that cycle. Flush during flush_pend ignored (no double emit).
//   Flush with fill_cnt==BYTES: full word emitted with m_last=1.
//  Simultaneous flush and byte arrival: arriving byte included in the flushed word.
//  Counters are width ceil(log2(BYTES+1)); no wrap possible by construction.
// TESTING
//  1 Reset, FIFO preloaded 01..08, m_ready=1 -> words 0x04030201, 0x08070605, keep=F, last=0,
//    fifo_rd high 8 consecutive cycles.
//  2 FIFO holds 01..08, m_ready=0 for 20 cycles -> exactly 8 pops, m_data 0x04030201 held,
//    2nd word held in assembly; m_ready=1 -> both words delivered in order.
//  3 Push AA,BB, then flush pulse -> one word 0x0000BBAA, keep=0011, last=1; busy then falls to 0.
//  4 Flush with empty assembly and no in-flight byte -> no m_valid, busy returns 0 within 2 cycles.
//  5 Assert rst the cycle after a fifo_rd, FIFO returns 55 -> byte dropped, all outputs 0,
//    next word begins at lane 0.
//  6 Random fifo_empty and m_ready for 10k bytes -> scoreboard byte order exact,
//    no pop while empty, m_data stable while stalled.

Source files
------------

// File: rtl/fifo_word_reader.sv
// Byte-FIFO consumer: pops bytes, absorbs the one-cycle read latency, packs BYTES bytes
// little-endian into a word on a valid/ready master port; flush emits a trailing partial word.
module fifo_word_reader #(
    parameter int DATA_W = 8,
    parameter int BYTES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    output logic                    fifo_rd,
    input  logic [DATA_W-1:0]       fifo_data,
    input  logic                    flush,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W*BYTES-1:0] m_data,
    output logic [BYTES-1:0]        m_keep,
    output logic                    m_last,
    output logic                    busy
);
    localparam int WORD_W = DATA_W * BYTES;
    localparam int CNT_W  = $clog2(BYTES + 1);
    localparam logic [CNT_W:0] FULL_CNT = (CNT_W + 1)'(BYTES);
    localparam logic [CNT_W:0] FULL_M1  = (CNT_W + 1)'(BYTES - 1);

    logic [WORD_W-1:0] asm_q, asm_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic              inflight_q, inflight_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [BYTES-1:0]  keep_q, keep_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic              flush_pend_q, flush_pend_d;
    logic              busy_q, busy_d;

    logic              slot_free_s;
    logic [CNT_W:0]    occ_s;
    logic              pop_s;
    logic              word_full_s;
    logic              flush_go_s;

    // Low fill_cnt lanes set, LSB-contiguous.
    function automatic logic [BYTES-1:0] keep_mask(input logic [CNT_W-1:0] n);
        logic [BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (CNT_W'(i) < n) begin
                k[i] = 1'b1;
            end else begin
                k[i] = 1'b0;
            end
        end
        return k;
    endfunction

    // Pop decision: rule (b) lets the last byte of a word overlap with the word leaving.
    always_comb begin
        slot_free_s = !valid_q || m_ready;
        occ_s       = {1'b0, fill_q} + {{CNT_W{1'b0}}, inflight_q};
        pop_s       = 1'b0;
        if (!rst && !fifo_empty && !flush_pend_q) begin
            if (occ_s < FULL_CNT) begin
                pop_s = 1'b1;
            end else if (inflight_q && ({1'b0, fill_q} == FULL_M1) && slot_free_s) begin
                pop_s = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next-state: byte arrival into assembly, word/flush transfer to the output slot.
    always_comb begin
        asm_d        = asm_q;
        fill_d       = fill_q;
        data_d       = data_q;
        keep_d       = keep_q;
        last_d       = last_q;
        valid_d      = valid_q && !m_ready;
        flush_pend_d = flush_pend_q;
        inflight_d   = pop_s;

        if (inflight_q) begin
            for (int i = 0; i < BYTES; i++) begin
                if (fill_q == CNT_W'(i)) begin
                    asm_d[i*DATA_W +: DATA_W] = fifo_data;
                end else begin
                    asm_d[i*DATA_W +: DATA_W] = asm_q[i*DATA_W +: DATA_W];
                end
            end
            fill_d = fill_q + CNT_W'(1);
        end else begin
            fill_d = fill_q;
        end

        word_full_s = ({1'b0, fill_d} == FULL_CNT);
        // Flush waits for the in-flight byte so it lands in the flushed word.
        flush_go_s  = flush_pend_q && !inflight_q && slot_free_s;

        if (flush_go_s) begin
            flush_pend_d = 1'b0;
            if (fill_q != '0) begin
                data_d  = asm_q;
                keep_d  = keep_mask(fill_q);
                last_d  = 1'b1;
                valid_d = 1'b1;
                asm_d   = '0;
                fill_d  = '0;
            end else begin
                valid_d = valid_q && !m_ready;
            end
        end else if (word_full_s && slot_free_s) begin
            data_d  = asm_d;
            keep_d  = '1;
            last_d  = 1'b0;
            valid_d = 1'b1;
            asm_d   = '0;
            fill_d  = '0;
        end else begin
            valid_d = valid_q && !m_ready;
        end

        if (!flush_pend_q && flush) begin
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_d;
        end

        busy_d = (fill_d != '0) || inflight_d || valid_d || flush_pend_d;
    end

    // State register with synchronous reset; reset also drops any in-flight byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q        <= '0;
            fill_q       <= '0;
            inflight_q   <= 1'b0;
            data_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            fill_q       <= fill_d;
            inflight_q   <= inflight_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            last_q       <= last_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            busy_q       <= busy_d;
        end
    end

    assign fifo_rd = pop_s;
    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_keep  = keep_q;
    assign m_last  = last_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Scoreboard bench for fifo_word_reader: a byte-FIFO model feeds the DUT, expected words
// are queued as stimulus is built and compared when the sink accepts a word.
module tb_fifo_word_reader;
    localparam int DATA_W = 8;
    localparam int BYTES  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [7:0]  fifo_data;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        busy;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic [7:0] fifo_q[$];
    word_t      exp_q[$];

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc, pops, first_pop, last_pop, first_valid;
    bit    force_empty = 1'b0;
    bit    pend = 1'b0;
    logic [7:0] pend_byte;
    bit    prev_stall = 1'b0;
    word_t prev_word;

    fifo_word_reader #(.DATA_W(DATA_W), .BYTES(BYTES)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .fifo_data(fifo_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t e;
        e.d = d;
        e.k = k;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic reset_counters();
        cyc = 0;
        pops = 0;
        first_pop = -1;
        last_pop = -1;
        first_valid = -1;
    endtask

    // One clock cycle: sample before the edge, model the FIFO pop, present read data after it.
    task automatic tick();
        word_t w;
        word_t e;
        fifo_empty = (fifo_q.size() == 0) || force_empty;
        #1;
        w = {m_data, m_keep, m_last};
        if (!rst) begin
            if (prev_stall) check("hold", {m_valid, w}, {1'b1, prev_word});
            if (fifo_rd) begin
                check("pop_empty", fifo_empty, 1'b0);
                pend_byte = (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'hEE;
                pend = 1'b1;
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end else begin
                pend = 1'b0;
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                check("word_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word", w, e);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_word = w;
        end else begin
            check("rd_in_rst", fifo_rd, 1'b0);
            pend = 1'b0;
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        fifo_data = pend ? pend_byte : 8'($urandom_range(0, 255));
        cyc++;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [31:0] wd;
        logic [7:0]  b;
        rst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b0;
        fifo_data = 8'h00;
        fifo_empty = 1'b1;
        reset_counters();
        repeat (2) tick();
        check("rst_outputs", {m_valid, m_data, m_keep, m_last, busy}, 39'd0);

        // 1: preloaded 01..08, sink always ready
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        rst = 1'b0;
        m_ready = 1'b1;
        reset_counters();
        repeat (14) tick();
        check("t1_pops", pops, 8);
        check("t1_consecutive", last_pop - first_pop, 7);
        check("t1_latency", first_valid - first_pop, BYTES + 1);
        check("t1_words_left", exp_q.size(), 0);
        check("t1_idle", busy, 1'b0);

        // 2: sink stalled for 20 cycles
        reset_counters();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        repeat (20) tick();
        check("t2_pops", pops, 8);
        check("t2_valid", m_valid, 1'b1);
        check("t2_data", m_data, 32'h04030201);
        check("t2_busy", busy, 1'b1);
        m_ready = 1'b1;
        drain(20);

        // 3: partial word by flush
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        expect_word(32'h0000BBAA, 4'b0011, 1'b1);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain(10);
        repeat (2) tick();
        check("t3_busy", busy, 1'b0);

        // 4: flush with nothing assembled
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        check("t4_busy", busy, 1'b0);
        check("t4_valid", m_valid, 1'b0);

        // 7: flush while a full word waits in assembly behind a stalled slot
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(8'h10 + i));
        expect_word(32'h14131211, 4'hF, 1'b0);
        expect_word(32'h18171615, 4'hF, 1'b1);
        repeat (20) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        m_ready = 1'b1;
        drain(20);

        // 5: reset the cycle after a pop; the returning byte must be dropped
        reset_counters();
        fifo_q.push_back(8'h55);
        for (int i = 0; i < 6 && pops == 0; i++) tick();
        check("t5_pop", pops, 1);
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        fifo_q.push_back(8'h44);
        rst = 1'b1;
        tick();
        check("t5_outputs", {m_valid, m_data, m_keep, m_last, busy}, 39'd0);
        check("t5_rd_in_rst", fifo_rd, 1'b0);
        rst = 1'b0;
        expect_word(32'h44332211, 4'hF, 1'b0);
        drain(20);

        // 6: random empty/ready over 10k bytes
        for (int i = 0; i < 2500; i++) begin
            for (int j = 0; j < BYTES; j++) begin
                b = 8'($urandom_range(0, 255));
                fifo_q.push_back(b);
                wd[j*8 +: 8] = b;
            end
            expect_word(wd, 4'hF, 1'b0);
        end
        for (int i = 0; i < 60000 && exp_q.size() != 0; i++) begin
            force_empty = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        force_empty = 1'b0;
        check("t6_drain", exp_q.size(), 0);
        check("t6_fifo_used", fifo_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
